// File: rtl/pc_fetch.sv
// pc_fetch: dual-issue fetch front end. Owns the PC, keeps at most one
// 64-bit fetch in flight, and queues returned packets in a 2-entry FIFO
// that feeds the IF/ID register.
module pc_fetch #(
    parameter logic [31:0] RESET_PC = 32'h1c000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  stall,
    input  logic        flush,
    input  logic [31:0] new_pc,
    input  logic        branch_flag,
    input  logic [31:0] branch_target,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_rvalid,
    input  logic [63:0] inst_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst_1,
    output logic [31:0] if_inst_2,
    output logic        if_inst_2_valid
);
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst_1;
        logic [31:0] inst_2;
        logic        inst_2_valid;
    } entry_t;

    logic [31:0] pc;
    logic [31:0] req_pc;
    logic        outstanding;
    logic        discard;
    entry_t      fifo [2];
    logic        head;
    logic        tail;
    logic [1:0]  count;

    logic        redirect;
    logic [31:0] target;
    logic        resp;
    logic        push;
    logic        pop;
    logic        accept;
    logic [1:0]  occ_after;
    entry_t      push_entry;
    entry_t      head_entry;

    // Stall bits 6:2 and the low target bits are architecturally ignored.
    logic unused_inputs;
    assign unused_inputs = ^{stall[6:2], new_pc[1:0], branch_target[1:0]};

    // Redirect selection, response classification and FIFO handshakes.
    always_comb begin
        redirect  = flush | branch_flag;
        target    = flush ? {new_pc[31:2], 2'b00} : {branch_target[31:2], 2'b00};
        resp      = inst_rvalid & outstanding;
        push      = resp & ~discard & ~redirect;
        if_valid  = (count != 2'd0) & ~redirect;
        pop       = if_valid & ~stall[1];
        // FIFO occupancy after this edge; a new request needs a free slot
        // left over for its own response.
        occ_after = count + {1'b0, push} - {1'b0, pop};
        inst_req  = ~rst & ~redirect & ~stall[0]
                  & (~outstanding | (inst_rvalid & ~discard))
                  & (occ_after < 2'd2);
        inst_addr = {pc[31:3], 3'b000};
        accept    = inst_req & inst_addr_ok;

        // A request to the upper word only carries one useful instruction.
        push_entry.pc = req_pc;
        if (req_pc[2]) begin
            push_entry.inst_1       = inst_rdata[63:32];
            push_entry.inst_2       = 32'd0;
            push_entry.inst_2_valid = 1'b0;
        end else begin
            push_entry.inst_1       = inst_rdata[31:0];
            push_entry.inst_2       = inst_rdata[63:32];
            push_entry.inst_2_valid = 1'b1;
        end

        head_entry      = fifo[head];
        if_pc           = head_entry.pc;
        if_inst_1       = head_entry.inst_1;
        if_inst_2       = head_entry.inst_2;
        if_inst_2_valid = head_entry.inst_2_valid;
    end

    // Program counter and the PC of the request in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc     <= RESET_PC;
            req_pc <= RESET_PC;
        end else if (redirect) begin
            pc <= target;
        end else if (accept) begin
            pc     <= {pc[31:3], 3'b000} + 32'd8;
            req_pc <= pc;
        end
    end

    // Outstanding-request tracking; a redirect marks an in-flight fetch stale.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding <= 1'b0;
            discard     <= 1'b0;
        end else if (redirect) begin
            if (outstanding && !inst_rvalid) begin
                discard <= 1'b1;
            end else if (resp) begin
                outstanding <= 1'b0;
                discard     <= 1'b0;
            end
        end else if (accept) begin
            outstanding <= 1'b1;
        end else if (resp) begin
            outstanding <= 1'b0;
            discard     <= 1'b0;
        end
    end

    // Packet FIFO; emptied on redirect, push and pop may share an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= 1'b0;
            tail  <= 1'b0;
            count <= 2'd0;
            for (int i = 0; i < 2; i++) fifo[i] <= '0;
        end else if (redirect) begin
            head  <= 1'b0;
            tail  <= 1'b0;
            count <= 2'd0;
        end else begin
            if (push) begin
                fifo[tail] <= push_entry;
                tail       <= ~tail;
            end
            if (pop) head <= ~head;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end
endmodule

// File: tb/tb_pc_fetch.sv
// Bench for pc_fetch: a memory responder with programmable latency, a
// request checker and a packet monitor popping from expectation queues.
module tb_pc_fetch;
    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        branch_flag;
    logic [31:0] branch_target;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_rvalid = 1'b0;
    logic [63:0] inst_rdata = 64'd0;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst_1;
    logic [31:0] if_inst_2;
    logic        if_inst_2_valid;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] i1;
        logic [31:0] i2;
        logic        v2;
    } pkt_t;

    pkt_t        exp_pkt [$];
    logic [31:0] exp_req [$];
    int          pass_cnt = 0;
    int          tot_cnt = 0;
    int          mem_lat = 0;
    logic        mem_pend = 1'b0;
    logic [31:0] mem_addr = 32'd0;
    int          mem_wait = 0;

    pc_fetch #(.RESET_PC(32'h1c000000)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .new_pc(new_pc),
        .branch_flag(branch_flag), .branch_target(branch_target),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_rvalid(inst_rvalid), .inst_rdata(inst_rdata),
        .if_valid(if_valid), .if_pc(if_pc), .if_inst_1(if_inst_1),
        .if_inst_2(if_inst_2), .if_inst_2_valid(if_inst_2_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Memory word at address a is ~a; expected packet for a request PC p.
    function automatic pkt_t mk(input logic [31:0] p);
        logic [31:0] a;
        pkt_t r;
        a = {p[31:3], 3'b000};
        r.pc = p;
        if (p[2]) begin
            r.i1 = ~(a + 32'd4); r.i2 = 32'd0; r.v2 = 1'b0;
        end else begin
            r.i1 = ~a; r.i2 = ~(a + 32'd4); r.v2 = 1'b1;
        end
        return r;
    endfunction

    // Memory responder and request-address checker.
    always @(negedge clk) begin
        inst_rvalid = 1'b0;
        if (mem_pend) begin
            if (mem_wait == 0) begin
                inst_rvalid = 1'b1;
                inst_rdata  = {~(mem_addr + 32'd4), ~mem_addr};
                mem_pend    = 1'b0;
            end else begin
                mem_wait--;
            end
        end
        #2;
        if (inst_req && inst_addr_ok) begin
            if (exp_req.size() == 0) begin
                tot_cnt++;
                $display("FAIL req_extra: got addr %h expected no request", inst_addr);
            end else begin
                chk("req_addr", 128'(inst_addr), 128'(exp_req.pop_front()));
            end
            mem_pend = 1'b1;
            mem_addr = inst_addr;
            mem_wait = mem_lat;
        end
    end

    // Packet monitor: compares every packet the IF/ID side consumes.
    always @(negedge clk) begin
        pkt_t got;
        #2;
        if (if_valid && !stall[1]) begin
            got = {if_pc, if_inst_1, if_inst_2, if_inst_2_valid};
            if (exp_pkt.size() == 0) begin
                tot_cnt++;
                $display("FAIL pkt_extra: got pc %h expected no packet", if_pc);
            end else begin
                chk("pkt", 128'(got), 128'(exp_pkt.pop_front()));
            end
        end
    end

    task automatic drain(input string nm);
        repeat (4) @(negedge clk);
        #3;
        chk({nm, "_req_left"}, 128'(exp_req.size()), 128'(0));
        chk({nm, "_pkt_left"}, 128'(exp_pkt.size()), 128'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; stall = 7'd0; flush = 1'b0; new_pc = 32'd0;
        branch_flag = 1'b0; branch_target = 32'd0; inst_addr_ok = 1'b1;
        repeat (2) @(negedge clk);
        #3;
        chk("rst_req",   128'(inst_req),        128'(0));
        chk("rst_addr",  128'(inst_addr),       128'(32'h1c000000));
        chk("rst_valid", 128'(if_valid),        128'(0));
        chk("rst_pc",    128'(if_pc),           128'(0));
        chk("rst_i1",    128'(if_inst_1),       128'(0));
        chk("rst_i2",    128'(if_inst_2),       128'(0));
        chk("rst_v2",    128'(if_inst_2_valid), 128'(0));

        // Sequential fetch, 1-cycle memory.
        foreach (exp_req[i]) exp_req.delete(i);
        exp_req.push_back(32'h1c000000); exp_req.push_back(32'h1c000008);
        exp_req.push_back(32'h1c000010); exp_req.push_back(32'h1c000018);
        exp_pkt.push_back(mk(32'h1c000000)); exp_pkt.push_back(mk(32'h1c000008));
        exp_pkt.push_back(mk(32'h1c000010)); exp_pkt.push_back(mk(32'h1c000018));
        @(negedge clk); rst = 1'b0;
        repeat (4) @(negedge clk);
        stall = 7'd1;
        drain("seq");

        // Backpressure: IF output held for 6 cycles.
        exp_req.push_back(32'h1c000020); exp_req.push_back(32'h1c000028);
        exp_req.push_back(32'h1c000030);
        exp_pkt.push_back(mk(32'h1c000020)); exp_pkt.push_back(mk(32'h1c000028));
        exp_pkt.push_back(mk(32'h1c000030));
        @(negedge clk); stall = 7'd2;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            if (i >= 3) begin
                #3;
                chk("bp_req",   128'(inst_req), 128'(0));
                chk("bp_head",  128'(if_pc),    128'(32'h1c000020));
                chk("bp_valid", 128'(if_valid), 128'(1));
            end
        end
        @(negedge clk); stall = 7'd0;
        @(negedge clk); stall = 7'd1;
        drain("bp");

        // Flush while a request is outstanding; stale data lands 2 cycles later.
        exp_req.push_back(32'h1c000038); exp_req.push_back(32'h00000008);
        exp_pkt.push_back(mk(32'h0000000c));
        @(negedge clk); stall = 7'd0; mem_lat = 2;
        @(negedge clk); flush = 1'b1; new_pc = 32'h0000000c;
        #3;
        chk("fl_valid", 128'(if_valid), 128'(0));
        chk("fl_req",   128'(inst_req), 128'(0));
        @(negedge clk); flush = 1'b0; mem_lat = 0;
        #3;
        chk("fl_wait", 128'(inst_req), 128'(0));
        @(negedge clk);
        #3;
        chk("fl_drop", 128'(inst_req), 128'(0));
        @(negedge clk);
        #3;
        chk("fl_req1", 128'(inst_req),  128'(1));
        chk("fl_addr", 128'(inst_addr), 128'(32'h00000008));
        @(negedge clk); stall = 7'd1;
        drain("fl");

        // Misaligned branch target.
        exp_req.push_back(32'h1c000010); exp_req.push_back(32'h1c000018);
        exp_pkt.push_back(mk(32'h1c000014)); exp_pkt.push_back(mk(32'h1c000018));
        @(negedge clk); stall = 7'd0; branch_flag = 1'b1; branch_target = 32'h1c000016;
        #3;
        chk("br_req", 128'(inst_req), 128'(0));
        @(negedge clk); branch_flag = 1'b0;
        #3;
        chk("br_addr", 128'(inst_addr), 128'(32'h1c000010));
        @(negedge clk);
        @(negedge clk); stall = 7'd1;
        drain("br");

        // Flush and branch together, with a packet held in the FIFO.
        exp_req.push_back(32'h1c000020); exp_req.push_back(32'h1c000028);
        exp_req.push_back(32'h00000008);
        exp_pkt.push_back(mk(32'h0000000c));
        @(negedge clk); stall = 7'd2;
        @(negedge clk);
        @(negedge clk);
        stall = 7'd0; flush = 1'b1; new_pc = 32'h0000000c;
        branch_flag = 1'b1; branch_target = 32'h1c000100;
        #3;
        chk("fb_valid", 128'(if_valid), 128'(0));
        chk("fb_req",   128'(inst_req), 128'(0));
        @(negedge clk); flush = 1'b0; branch_flag = 1'b0;
        #3;
        chk("fb_clear", 128'(if_valid),  128'(0));
        chk("fb_addr",  128'(inst_addr), 128'(32'h00000008));
        @(negedge clk); stall = 7'd1;
        drain("fb");

        // Reset while a request is outstanding; its late response is ignored.
        exp_req.push_back(32'h00000010); exp_req.push_back(32'h1c000000);
        exp_pkt.push_back(mk(32'h1c000000));
        @(negedge clk); stall = 7'd0; mem_lat = 2;
        @(negedge clk); rst = 1'b1;
        #3;
        chk("rr_req",   128'(inst_req),        128'(0));
        chk("rr_addr",  128'(inst_addr),       128'(32'h1c000000));
        chk("rr_valid", 128'(if_valid),        128'(0));
        chk("rr_pc",    128'(if_pc),           128'(0));
        chk("rr_i1",    128'(if_inst_1),       128'(0));
        chk("rr_i2",    128'(if_inst_2),       128'(0));
        chk("rr_v2",    128'(if_inst_2_valid), 128'(0));
        @(negedge clk); rst = 1'b0; stall = 7'd1; mem_lat = 0;
        @(negedge clk);
        @(negedge clk); stall = 7'd0;
        #3;
        chk("rr_late",  128'(if_valid),  128'(0));
        chk("rr_req1",  128'(inst_req),  128'(1));
        chk("rr_addr1", 128'(inst_addr), 128'(32'h1c000000));
        @(negedge clk); stall = 7'd1;
        drain("rr");

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule
